imm_gen_pipe: RTL and testbench

Parametrised, buffered immediate generator for the decode stage. It accepts one instruction word per cycle over a valid/ready handshake and decodes every RV base format (R/I/S/B/U/J, including shift-immediates and JALR) into an XLEN-wide immediate with sign or zero extension. Results are held in a 2-entry elastic buffer feeding the register-read stage. The block also flags and counts illegal opcodes.

---
 rtl/imm_gen_pipe.sv | 149 ++++++++++++++
 tb/tb_imm_gen_pipe.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator: decodes RV base formats into an XLEN-wide
// immediate and buffers results in a 2-entry elastic FIFO with illegal-opcode counting.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic             sign_ext,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic [CNT_W-1:0] ill_cnt
);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  logic [31:0]     raw32;
  logic            fill;
  logic [2:0]      dec_fmt;
  logic [XLEN-1:0] dec_imm;

  logic [XLEN-1:0] imm_mem [2];
  logic [2:0]      fmt_mem [2];
  logic            wr_ptr;
  logic            rd_ptr;
  logic [1:0]      count;
  logic            push;
  logic            pop;

  // Every format's field MSB is instr[31], so one fill bit serves all signed formats.
  always_comb begin
    dec_fmt = FMT_ILL;
    raw32   = 32'd0;
    fill    = sign_ext & in_instr[31];
    case (in_instr[6:0])
      7'b0010011: begin
        dec_fmt = FMT_I;
        if (in_instr[13:12] == 2'b01) begin
          fill  = 1'b0;
          raw32 = {26'd0, ((XLEN == 64) ? in_instr[25] : 1'b0), in_instr[24:20]};
        end else begin
          raw32 = {{20{fill}}, in_instr[31:20]};
        end
      end
      7'b0000011, 7'b1100111: begin
        dec_fmt = FMT_I;
        raw32   = {{20{fill}}, in_instr[31:20]};
      end
      7'b0100011: begin
        dec_fmt = FMT_S;
        raw32   = {{20{fill}}, in_instr[31:25], in_instr[11:7]};
      end
      7'b1100011: begin
        dec_fmt = FMT_B;
        raw32   = {{19{fill}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec_fmt = FMT_U;
        raw32   = {in_instr[31:12], 12'd0};
      end
      7'b1101111: begin
        dec_fmt = FMT_J;
        raw32   = {{11{fill}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
      end
      7'b0110011: begin
        dec_fmt = FMT_R;
        fill    = 1'b0;
      end
      default: begin
        dec_fmt = FMT_ILL;
        fill    = 1'b0;
      end
    endcase
  end

  // Widen the 32-bit field to XLEN, replicating the fill bit above bit 31.
  always_comb begin
    dec_imm = '0;
    for (int i = 0; i < XLEN; i++) begin
      if (i < 32) begin
        dec_imm[i] = raw32[i % 32];
      end else begin
        dec_imm[i] = fill;
      end
    end
  end

  assign in_ready  = rst_n && (count != 2'd2) && !flush;
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_imm   = out_valid ? imm_mem[rd_ptr] : '0;
  assign out_fmt   = out_valid ? fmt_mem[rd_ptr] : 3'd0;

  // FIFO storage, pointers and occupancy; flush wins over push and pop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      imm_mem[0] <= '0;
      imm_mem[1] <= '0;
      fmt_mem[0] <= 3'd0;
      fmt_mem[1] <= 3'd0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      count      <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        imm_mem[wr_ptr] <= dec_imm;
        fmt_mem[wr_ptr] <= dec_fmt;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Saturating illegal-opcode counter; only reset clears it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ill_cnt <= '0;
    end else if (push && (dec_fmt == FMT_ILL) && (ill_cnt != {CNT_W{1'b1}})) begin
      ill_cnt <= ill_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      ill_cnt <= ill_cnt;
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: an XLEN=32/CNT_W=8 and an XLEN=64/CNT_W=2
// instance share stimulus and are compared every cycle against a queue-based model.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        sign_ext;
  logic        flush;
  logic        out_ready;

  logic        in_ready_a, out_valid_a;
  logic [31:0] out_imm_a;
  logic [2:0]  out_fmt_a;
  logic [7:0]  ill_cnt_a;

  logic        in_ready_b, out_valid_b;
  logic [63:0] out_imm_b;
  logic [2:0]  out_fmt_b;
  logic [1:0]  ill_cnt_b;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_instr(in_instr), .sign_ext(sign_ext), .flush(flush),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_imm(out_imm_a),
    .out_fmt(out_fmt_a), .ill_cnt(ill_cnt_a)
  );

  imm_gen_pipe #(.XLEN(64), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_instr(in_instr), .sign_ext(sign_ext), .flush(flush),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_imm(out_imm_b),
    .out_fmt(out_fmt_b), .ill_cnt(ill_cnt_b)
  );

  typedef struct {
    logic [31:0] imm32;
    logic [63:0] imm64;
    logic [2:0]  fmt;
  } exp_t;

  exp_t        q[$];
  int unsigned ill_ref;
  int          n_cmp;
  int          n_bad;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ext(input logic [63:0] raw, input int w, input bit sgn);
    if (sgn && raw[w-1]) return raw | (~64'd0 << w);
    return raw;
  endfunction

  // Reference decode written from the format tables with shifts and masks.
  function automatic void ref_decode(input logic [31:0] ins, input bit sgn, input int xlen,
                                     output logic [63:0] imm, output logic [2:0] fmt);
    logic [63:0] x;
    int unsigned f3;
    x  = {32'd0, ins};
    f3 = (ins >> 12) & 7;
    case (ins & 32'h7f)
      32'h13: begin
        fmt = 3'd1;
        if (f3 == 1 || f3 == 5) imm = (xlen == 32) ? ((x >> 20) & 64'h1f) : ((x >> 20) & 64'h3f);
        else imm = ext((x >> 20) & 64'hfff, 12, sgn);
      end
      32'h03, 32'h67: begin fmt = 3'd1; imm = ext((x >> 20) & 64'hfff, 12, sgn); end
      32'h23: begin fmt = 3'd2; imm = ext(((x >> 25) << 5) | ((x >> 7) & 64'h1f), 12, sgn); end
      32'h63: begin
        fmt = 3'd3;
        imm = ext(((x >> 31) << 12) | (((x >> 7) & 64'h1) << 11) |
                  (((x >> 25) & 64'h3f) << 5) | (((x >> 8) & 64'hf) << 1), 13, sgn);
      end
      32'h37, 32'h17: begin fmt = 3'd4; imm = ext((x >> 12) << 12, 32, sgn); end
      32'h6f: begin
        fmt = 3'd5;
        imm = ext(((x >> 31) << 20) | (((x >> 12) & 64'hff) << 12) |
                  (((x >> 20) & 64'h1) << 11) | (((x >> 21) & 64'h3ff) << 1), 21, sgn);
      end
      32'h33: begin fmt = 3'd0; imm = 64'd0; end
      default: begin fmt = 3'd7; imm = 64'd0; end
    endcase
  endfunction

  // One clock cycle: drive at negedge, check outputs, then advance the model at posedge.
  task automatic step(input logic iv, input logic [31:0] ins, input logic sg,
                      input logic ordy, input logic fl, output bit acc);
    bit   rdy_exp, pop;
    exp_t e;
    logic [63:0] i64;
    logic [2:0]  f;
    in_valid = iv; in_instr = ins; sign_ext = sg; out_ready = ordy; flush = fl;
    #1;
    rdy_exp = rst_n && (q.size() != 2) && !fl;
    check_eq("in_ready_a", {63'd0, in_ready_a}, {63'd0, rdy_exp});
    check_eq("in_ready_b", {63'd0, in_ready_b}, {63'd0, rdy_exp});
    check_eq("out_valid_a", {63'd0, out_valid_a}, {63'd0, q.size() != 0});
    check_eq("out_valid_b", {63'd0, out_valid_b}, {63'd0, q.size() != 0});
    check_eq("out_imm_a", {32'd0, out_imm_a}, (q.size() != 0) ? {32'd0, q[0].imm32} : 64'd0);
    check_eq("out_imm_b", out_imm_b, (q.size() != 0) ? q[0].imm64 : 64'd0);
    check_eq("out_fmt_a", {61'd0, out_fmt_a}, (q.size() != 0) ? {61'd0, q[0].fmt} : 64'd0);
    check_eq("out_fmt_b", {61'd0, out_fmt_b}, (q.size() != 0) ? {61'd0, q[0].fmt} : 64'd0);
    check_eq("ill_cnt_a", {56'd0, ill_cnt_a}, (ill_ref > 255) ? 64'd255 : 64'(ill_ref));
    check_eq("ill_cnt_b", {62'd0, ill_cnt_b}, (ill_ref > 3) ? 64'd3 : 64'(ill_ref));
    acc = iv && rdy_exp;
    pop = (q.size() != 0) && ordy;
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      ill_ref = 0;
    end else if (fl) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) begin
        ref_decode(ins, sg, 32, i64, f);
        e.imm32 = i64[31:0];
        ref_decode(ins, sg, 64, e.imm64, e.fmt);
        q.push_back(e);
        if (e.fmt == 3'd7) ill_ref++;
      end
    end
    @(negedge clk);
  endtask

  // Holds a word on the input until accepted, bounded to a few cycles.
  task automatic send(input logic [31:0] ins, input logic sg, input logic ordy);
    bit acc;
    acc = 1'b0;
    for (int k = 0; k < 8 && !acc; k++) step(1'b1, ins, sg, ordy, 1'b0, acc);
    if (!acc) check_eq("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle(input logic ordy, input int n);
    bit acc;
    for (int k = 0; k < n; k++) step(1'b0, 32'd0, 1'b0, ordy, 1'b0, acc);
  endtask

  logic [6:0] ops [11] = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37,
                           7'h17, 7'h6f, 7'h33, 7'h7f, 7'h13};

  initial begin
    bit acc;
    logic [31:0] w;
    n_cmp = 0; n_bad = 0; ill_ref = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_instr = 32'd0; sign_ext = 1'b0;
    flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    idle(1'b0, 1);          // reset state checked while rst_n is still low
    rst_n = 1'b1;

    // Extension and per-format decode
    send(32'hFFF00093, 1'b1, 1'b1);
    send(32'hFFF00093, 1'b0, 1'b1);
    send(32'h12345037, 1'b1, 1'b1);
    send(32'h0040006F, 1'b1, 1'b1);
    send(32'hFE000EE3, 1'b1, 1'b1);
    send(32'h4030D093, 1'b1, 1'b1);
    send(32'h4200D093, 1'b1, 1'b1);   // shamt bit 5 set: differs between XLENs
    send(32'h002081B3, 1'b1, 1'b1);
    idle(1'b1, 2);

    // Backpressure: third word waits until a pop frees a slot
    send(32'h00100093, 1'b1, 1'b0);
    send(32'h00200093, 1'b1, 1'b0);
    step(1'b1, 32'h00300093, 1'b1, 1'b0, 1'b0, acc);
    check_eq("bp_third_blocked", {63'd0, acc}, 64'd0);
    send(32'h00300093, 1'b1, 1'b1);
    idle(1'b1, 3);

    // Illegal opcodes and saturation of the narrow counter
    for (int k = 0; k < 4; k++) send(32'h0000007F, 1'b1, 1'b1);
    idle(1'b1, 2);
    check_eq("ill_sat_b", {62'd0, ill_cnt_b}, 64'd3);
    check_eq("ill_cnt_a4", {56'd0, ill_cnt_a}, 64'd4);

    // Flush with a full buffer and a valid input
    send(32'h0000007F, 1'b0, 1'b0);
    send(32'hABCDE037, 1'b0, 1'b0);
    step(1'b1, 32'h0000007F, 1'b0, 1'b1, 1'b1, acc);
    check_eq("flush_no_accept", {63'd0, acc}, 64'd0);
    idle(1'b1, 1);

    // Reset mid-stream with a full buffer
    send(32'h00500093, 1'b1, 1'b0);
    send(32'hFFF00093, 1'b1, 1'b0);
    rst_n = 1'b0;
    idle(1'b0, 1);
    rst_n = 1'b1;
    send(32'hFE000EE3, 1'b1, 1'b1);
    idle(1'b1, 2);

    // Randomized traffic with occasional flushes
    for (int k = 0; k < 400; k++) begin
      w = $urandom;
      if ($urandom_range(0, 9) != 0) w[6:0] = ops[$urandom_range(0, 10)];
      step($urandom_range(0, 3) != 0, w, $urandom_range(0, 1) == 1,
           $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0, acc);
    end
    idle(1'b1, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
